// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake and register-file port bundle for alu_exec_ctrl.
// The controller connects through the slave modport; its environment uses master.
interface alu_exec_ctrl_if;
    logic        in_instr_valid;
    logic        o_instr_ready;
    logic [3:0]  in_opcode;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [3:0]  o_r_add1;
    logic [3:0]  o_r_add2;
    logic [15:0] in_r_data1;
    logic [15:0] in_r_data2;
    logic [15:0] o_w_data;
    logic [3:0]  o_w_add;
    logic        o_w_en;
    logic        o_busy;
    logic        o_done;
    logic        o_zero;
    logic        o_carry;

    modport master (
        output in_instr_valid, in_opcode, in_rd, in_rs1, in_rs2,
        output in_r_data1, in_r_data2,
        input  o_instr_ready, o_r_add1, o_r_add2, o_w_data, o_w_add,
        input  o_w_en, o_busy, o_done, o_zero, o_carry
    );

    modport slave (
        input  in_instr_valid, in_opcode, in_rd, in_rs1, in_rs2,
        input  in_r_data1, in_r_data2,
        output o_instr_ready, o_r_add1, o_r_add2, o_w_data, o_w_add,
        output o_w_en, o_busy, o_done, o_zero, o_carry
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute/write-back controller: IDLE -> READ -> EXEC -> WB, with a
// 16-step shift-add multiplier and zero/carry flags updated on write-back.
module alu_exec_ctrl (
    input  logic           in_clk,
    input  logic           in_rst,
    alu_exec_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  rd_q, rd_d;
    logic [3:0]  rs1_q, rs1_d;
    logic [3:0]  rs2_q, rs2_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        w_en_q, w_en_d;
    logic        done_q, done_d;
    logic [15:0] w_data_q, w_data_d;
    logic [3:0]  w_add_q, w_add_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;

    logic [16:0] sum;
    logic [31:0] shl_w;
    logic [31:0] shr_w;
    logic [31:0] mul_step;
    logic [31:0] mul_next;
    logic [15:0] alu_res;
    logic        alu_carry;
    logic        alu_writes;
    logic        exec_last;

    // Shifts run through a 32-bit window so the last bit shifted out lands at a
    // fixed position; a zero shift amount leaves that position clear.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        sum        = {1'b0, a_q} + {1'b0, b_q};
        shl_w      = {16'h0000, a_q} << b_q[3:0];
        shr_w      = {a_q, 16'h0000} >> b_q[3:0];
        mul_step   = b_q[cnt_q] ? ({16'h0000, a_q} << cnt_q) : 32'h0000_0000;
        mul_next   = acc_q + mul_step;
        alu_res    = 16'h0000;
        alu_carry  = 1'b0;
        alu_writes = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum[15:0];
                alu_carry = sum[16];
            end
            OP_SUB: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res   = shl_w[15:0];
                alu_carry = shl_w[16];
            end
            OP_SHR: begin
                alu_res   = shr_w[31:16];
                alu_carry = shr_w[15];
            end
            OP_MUL: begin
                alu_res   = mul_next[15:0];
                alu_carry = |mul_next[31:16];
            end
            OP_MOV: alu_res = a_q;
            default: alu_writes = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        w_en_d    = 1'b0;
        done_d    = 1'b0;
        w_data_d  = w_data_q;
        w_add_d   = w_add_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        exec_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_instr_valid) begin
                    op_d    = bus.in_opcode;
                    rd_d    = bus.in_rd;
                    rs1_d   = bus.in_rs1;
                    rs2_d   = bus.in_rs2;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = bus.in_r_data1;
                b_d     = bus.in_r_data2;
                acc_d   = 32'h0000_0000;
                cnt_d   = 4'd0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == OP_MUL) begin
                    acc_d     = mul_next;
                    cnt_d     = cnt_q + 4'd1;
                    exec_last = (cnt_q == 4'd15);
                end else begin
                    exec_last = 1'b1;
                end
                // Strobe and flags are registered on the edge that enters WB.
                if (exec_last) begin
                    state_d = S_WB;
                    done_d  = 1'b1;
                    if (alu_writes) begin
                        w_en_d   = 1'b1;
                        w_data_d = alu_res;
                        w_add_d  = rd_q;
                        zero_d   = (alu_res == 16'h0000);
                        carry_d  = alu_carry;
                    end
                end
            end
            S_WB: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (in_rst) begin
            state_q  <= S_IDLE;
            op_q     <= 4'd0;
            rd_q     <= 4'd0;
            rs1_q    <= 4'd0;
            rs2_q    <= 4'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            acc_q    <= 32'h0000_0000;
            cnt_q    <= 4'd0;
            w_en_q   <= 1'b0;
            done_q   <= 1'b0;
            w_data_q <= 16'h0000;
            w_add_q  <= 4'd0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            w_en_q   <= w_en_d;
            done_q   <= done_d;
            w_data_q <= w_data_d;
            w_add_q  <= w_add_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.o_instr_ready = (state_q == S_IDLE);
    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_r_add1      = rs1_q;
    assign bus.o_r_add2      = rs2_q;
    assign bus.o_w_en        = w_en_q;
    assign bus.o_done        = done_q;
    assign bus.o_w_data      = w_data_q;
    assign bus.o_w_add       = w_add_q;
    assign bus.o_zero        = zero_q;
    assign bus.o_carry       = carry_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: register-file model, cycle-level reference model with
// per-cycle compare, and directed instructions with hand-computed results.
module tb_alu_exec_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_ctrl_if bus();

    alu_exec_ctrl dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] rf       [16] = '{default: 16'h0000};
    logic [15:0] model_rf [16] = '{default: 16'h0000};
    logic        pre_en   = 1'b0;
    logic [3:0]  pre_addr = 4'd0;
    logic [15:0] pre_val  = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: DUT writes take priority; bench presets only while idle.
    always @(posedge clk) begin
        if (bus.o_w_en) rf[bus.o_w_add] <= bus.o_w_data;
        else if (pre_en) rf[pre_addr] <= pre_val;
    end
    assign bus.in_r_data1 = rf[bus.o_r_add1];
    assign bus.in_r_data2 = rf[bus.o_r_add2];

    // Reference ALU from the opcode table, in plain arithmetic.
    function automatic void model_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output logic c, output logic wr);
        longint p;
        int     sh;
        sh = int'(b % 16);
        r  = 16'h0000;
        c  = 1'b0;
        wr = 1'b1;
        case (op)
            4'd0: begin p = longint'(a) + longint'(b); r = p[15:0]; c = (p > 65535); end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = a << sh; c = (sh != 0) && a[16 - sh]; end
            4'd6: begin r = a >> sh; c = (sh != 0) && a[sh - 1]; end
            4'd7: begin p = longint'(a) * longint'(b); r = p[15:0]; c = ((p >> 16) != 0); end
            4'd8: r = a;
            default: wr = 1'b0;
        endcase
    endfunction

    // Cycle-level model: accept when idle and valid, write-back 3 (or 18 for MUL)
    // cycles after the accept cycle, idle again the cycle after.
    bit          m_on = 0;
    bit          m_pend = 0;
    bit          m_rdy;
    bit          m_at_wb;
    int          m_wb = 0;
    logic        m_wr = 1'b0;
    logic        m_c = 1'b0;
    logic [15:0] m_res = 16'h0000;
    logic [3:0]  m_rd = 4'd0;
    logic [3:0]  m_ra1 = 4'd0;
    logic [3:0]  m_ra2 = 4'd0;
    logic [15:0] m_wdata = 16'h0000;
    logic [3:0]  m_wadd = 4'd0;
    logic        m_z = 1'b0;
    logic        m_cf = 1'b0;

    always @(negedge clk) begin
        if (pre_en) model_rf[pre_addr] = pre_val;
        m_rdy = !m_pend;
        if (m_on) begin
            m_at_wb = m_pend && (cyc == m_wb);
            if (m_at_wb && m_wr) begin
                m_wdata = m_res;
                m_wadd  = m_rd;
                m_z     = (m_res == 16'h0000);
                m_cf    = m_c;
                model_rf[m_rd] = m_res;
            end
            check("cyc_ready",  bus.o_instr_ready, m_rdy);
            check("cyc_busy",   bus.o_busy, !m_rdy);
            check("cyc_w_en",   bus.o_w_en, m_at_wb && m_wr);
            check("cyc_done",   bus.o_done, m_at_wb);
            check("cyc_w_data", bus.o_w_data, m_wdata);
            check("cyc_w_add",  bus.o_w_add, m_wadd);
            check("cyc_zero",   bus.o_zero, m_z);
            check("cyc_carry",  bus.o_carry, m_cf);
            check("cyc_r_add1", bus.o_r_add1, m_ra1);
            check("cyc_r_add2", bus.o_r_add2, m_ra2);
            if (m_at_wb) m_pend = 0;
        end
        if (rst) begin
            m_on = 1; m_pend = 0; m_wdata = 16'h0000; m_wadd = 4'd0;
            m_z = 1'b0; m_cf = 1'b0; m_ra1 = 4'd0; m_ra2 = 4'd0;
        end else if (m_on && m_rdy && bus.in_instr_valid) begin
            m_pend = 1;
            m_wb   = cyc + ((bus.in_opcode == 4'd7) ? 18 : 3);
            m_rd   = bus.in_rd;
            m_ra1  = bus.in_rs1;
            m_ra2  = bus.in_rs2;
            model_alu(bus.in_opcode, model_rf[bus.in_rs1], model_rf[bus.in_rs2], m_res, m_c, m_wr);
        end
    end

    task automatic set_reg(input logic [3:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_val = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    endtask

    // Waits (bounded) for a negedge with ready high; the following edge accepts.
    task automatic wait_ready(output int t);
        bit got = 0;
        t = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.o_instr_ready === 1'b1) begin got = 1; t = cyc; end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, output int t);
        @(posedge clk); #1;
        drive(op, rd, rs1, rs2);
        bus.in_instr_valid = 1'b1;
        wait_ready(t);
        @(posedge clk); #1;
        bus.in_instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int t);
        bit got = 0;
        t = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin got = 1; t = cyc; end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [3:0] rd,
                       input logic [15:0] exp_data, input logic exp_we,
                       input logic exp_z, input logic exp_c, input int lat);
        int t, d;
        issue(op, rd, 4'd1, 4'd2, t);
        wait_done(d);
        check({name, "_latency"}, d - t, lat);
        check({name, "_w_en"}, bus.o_w_en, exp_we);
        if (exp_we) begin
            check({name, "_w_data"}, bus.o_w_data, exp_data);
            check({name, "_w_add"}, bus.o_w_add, rd);
        end
        check({name, "_zero"}, bus.o_zero, exp_z);
        check({name, "_carry"}, bus.o_carry, exp_c);
    endtask

    initial begin
        int t, t2, d, wen_seen;
        bus.in_instr_valid = 1'b0;
        drive(4'd0, 4'd0, 4'd0, 4'd0);

        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.o_instr_ready, 1'b1);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_w_en", bus.o_w_en, 1'b0);
        check("rst_w_data", bus.o_w_data, 16'h0000);
        check("rst_flags", {bus.o_zero, bus.o_carry}, 2'b00);

        set_reg(4'd1, 16'h7FFF); set_reg(4'd2, 16'h0001);
        run("add_ovf", 4'd0, 4'd3, 16'h8000, 1'b1, 1'b0, 1'b0, 3);
        set_reg(4'd1, 16'hFFFF);
        run("add_wrap", 4'd0, 4'd3, 16'h0000, 1'b1, 1'b1, 1'b1, 3);
        set_reg(4'd1, 16'h0003); set_reg(4'd2, 16'h0005);
        run("sub_borrow", 4'd1, 4'd4, 16'hFFFE, 1'b1, 1'b0, 1'b1, 3);
        set_reg(4'd1, 16'h8001); set_reg(4'd2, 16'h0001);
        run("shl", 4'd5, 4'd4, 16'h0002, 1'b1, 1'b0, 1'b1, 3);
        run("shr", 4'd6, 4'd5, 16'h4000, 1'b1, 1'b0, 1'b1, 3);
        set_reg(4'd2, 16'h0000);
        run("shl_zero", 4'd5, 4'd6, 16'h8001, 1'b1, 1'b0, 1'b0, 3);
        run("nop", 4'd9, 4'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 3);
        set_reg(4'd1, 16'h0123); set_reg(4'd2, 16'h0010);
        run("mul", 4'd7, 4'd8, 16'h1230, 1'b1, 1'b0, 1'b0, 18);
        set_reg(4'd1, 16'h1000);
        run("mul_ovf", 4'd7, 4'd8, 16'h0000, 1'b1, 1'b1, 1'b1, 18);

        // Reset during the tenth cycle after a MUL accept.
        issue(4'd7, 4'd9, 4'd1, 4'd2, t);
        for (int i = 0; i < 40 && cyc != t + 10; i++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", bus.o_instr_ready, 1'b1);
        check("midrst_busy", bus.o_busy, 1'b0);
        check("midrst_flags", {bus.o_zero, bus.o_carry}, 2'b00);
        wen_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_w_en === 1'b1) wen_seen++;
        end
        check("midrst_no_write", wen_seen, 0);
        check("midrst_r9_kept", rf[9], 16'h0000);

        // Back-to-back accepts with valid held high; second one aliases rd/rs.
        set_reg(4'd1, 16'h0001); set_reg(4'd2, 16'h0002); set_reg(4'd5, 16'h0004);
        @(posedge clk); #1;
        drive(4'd0, 4'd6, 4'd1, 4'd2);
        bus.in_instr_valid = 1'b1;
        wait_ready(t);
        @(posedge clk); #1;
        drive(4'd0, 4'd5, 4'd5, 4'd5);
        wait_ready(t2);
        @(posedge clk); #1;
        bus.in_instr_valid = 1'b0;
        check("queue_gap", t2 - t, 4);
        wait_done(d);
        check("queue_latency", d - t2, 3);
        @(posedge clk); #1;
        check("queue_r6", rf[6], 16'h0003);
        check("queue_r5", rf[5], 16'h0008);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
